// File: rtl/conv_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one conv_layer between several pixel sources.
// A grant covers one whole frame and is held until its last conv result has been consumed.
module conv_frame_arbiter #(
   parameter int unsigned LineWidthPx = 160,
   parameter int unsigned LineCountPx = 120,
   parameter int unsigned WidthIn     = 1,
   parameter int unsigned KernelWidth = 3,
   parameter int unsigned WeightWidth = 2,
   parameter int unsigned OutChannels = 1,
   parameter int unsigned Sources     = 2,
   localparam int unsigned SrcW       = (Sources > 1) ? $clog2(Sources) : 1,
   localparam int unsigned BankW      = OutChannels * KernelWidth * KernelWidth * WeightWidth
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [Sources-1:0]         src_valid_i,
   output logic [Sources-1:0]         src_ready_o,
   input  logic [Sources*WidthIn-1:0] src_data_i,
   input  logic [Sources*BankW-1:0]   src_weights_i,
   output logic                       conv_valid_o,
   input  logic                       conv_ready_i,
   output logic [WidthIn-1:0]         conv_data_o,
   output logic [BankW-1:0]           conv_weights_o,
   input  logic                       conv_out_valid_i,
   input  logic                       conv_out_ready_i,
   output logic [SrcW-1:0]            grant_o,
   output logic                       busy_o,
   output logic                       frame_done_o
);

   localparam int unsigned FramePx = LineWidthPx * LineCountPx;
   localparam int unsigned CntW    = $clog2(FramePx);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StStream = 2'd1;
   localparam logic [1:0] StDrain  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [SrcW-1:0]  grant_q, grant_d;
   logic [SrcW-1:0]  rr_q, rr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [BankW-1:0] weights_q, weights_d;

   // Round-robin pick: rotate the request vector so the rr pointer lands on bit 0.
   logic [2*Sources-1:0] valid_dbl;
   logic [Sources-1:0]   valid_rot;
   logic                 pick_found;
   logic [SrcW-1:0]      pick;
   int unsigned          pick_sum;

   always_comb begin
      valid_dbl  = {src_valid_i, src_valid_i};
      valid_rot  = Sources'(valid_dbl >> rr_q);
      pick_found = 1'b0;
      pick       = '0;
      pick_sum   = 0;
      for (int unsigned j = 0; j < Sources; j++) begin
         if (!pick_found && valid_rot[j]) begin
            pick_found = 1'b1;
            pick_sum   = 32'(rr_q) + j;
            if (pick_sum >= Sources) begin
               pick_sum = pick_sum - Sources;
            end
            pick = SrcW'(pick_sum);
         end
      end
   end

   logic               sel_valid;
   logic [WidthIn-1:0] sel_data;
   logic [BankW-1:0]   pick_bank;

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      pick_bank = '0;
      for (int unsigned s = 0; s < Sources; s++) begin
         if (grant_q == SrcW'(s)) begin
            sel_valid = src_valid_i[s];
            sel_data  = src_data_i[s*WidthIn +: WidthIn];
         end
         if (pick == SrcW'(s)) begin
            pick_bank = src_weights_i[s*BankW +: BankW];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_d         = rr_q;
      cnt_d        = cnt_q;
      weights_d    = weights_q;
      conv_valid_o = 1'b0;
      conv_data_o  = '0;
      src_ready_o  = '0;
      frame_done_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d   = pick;
               weights_d = pick_bank;
               cnt_d     = '0;
               state_d   = StStream;
            end
         end
         StStream: begin
            conv_valid_o = sel_valid;
            conv_data_o  = sel_data;
            for (int unsigned s = 0; s < Sources; s++) begin
               if (grant_q == SrcW'(s)) begin
                  src_ready_o[s] = conv_ready_i;
               end
            end
            if (sel_valid && conv_ready_i) begin
               if (cnt_q == CntW'(FramePx - 1)) begin
                  cnt_d   = '0;
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDrain: begin
            // Retire once no conv result is pending or the last one is taken this cycle.
            if (!conv_out_valid_i || conv_out_ready_i) begin
               frame_done_o = 1'b1;
               rr_d         = (grant_q == SrcW'(Sources - 1)) ? '0 : grant_q + 1'b1;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         rr_q      <= '0;
         cnt_q     <= '0;
         weights_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         weights_q <= weights_d;
      end
   end

   assign grant_o        = grant_q;
   assign conv_weights_o = weights_q;
   assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_conv_frame_arbiter.sv
// Scoreboard bench for conv_frame_arbiter: randomized sources and sink, with a frame-level
// round-robin reference model feeding an expected-beat queue checked by an independent monitor.
`timescale 1ns/1ps
module tb_conv_frame_arbiter;

   localparam int unsigned LW   = 4;
   localparam int unsigned LC   = 3;
   localparam int unsigned FP   = LW * LC;
   localparam int unsigned NS   = 2;
   localparam int unsigned WIN  = 1;
   localparam int unsigned KW   = 3;
   localparam int unsigned WW   = 2;
   localparam int unsigned OC   = 1;
   localparam int unsigned BW   = OC * KW * KW * WW;
   localparam int unsigned MaxF = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS-1:0]     src_valid;
   logic [NS-1:0]     src_ready;
   logic [NS*WIN-1:0] src_data;
   logic [NS*BW-1:0]  src_weights;
   logic              conv_valid;
   logic              conv_ready;
   logic [WIN-1:0]    conv_data;
   logic [BW-1:0]     conv_weights;
   logic              out_valid;
   logic              out_ready;
   logic [0:0]        grant;
   logic              busy;
   logic              frame_done;

   always #5 clk = ~clk;

   conv_frame_arbiter #(
      .LineWidthPx(LW), .LineCountPx(LC), .WidthIn(WIN), .KernelWidth(KW),
      .WeightWidth(WW), .OutChannels(OC), .Sources(NS)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .src_valid_i     (src_valid),
      .src_ready_o     (src_ready),
      .src_data_i      (src_data),
      .src_weights_i   (src_weights),
      .conv_valid_o    (conv_valid),
      .conv_ready_i    (conv_ready),
      .conv_data_o     (conv_data),
      .conv_weights_o  (conv_weights),
      .conv_out_valid_i(out_valid),
      .conv_out_ready_i(out_ready),
      .grant_o         (grant),
      .busy_o          (busy),
      .frame_done_o    (frame_done)
   );

   typedef struct {
      int unsigned    src;
      logic [WIN-1:0] data;
      logic [BW-1:0]  w;
   } beat_t;

   beat_t          exp_q[$];
   logic [WIN-1:0] pdata [NS][MaxF*FP];
   logic [BW-1:0]  wbank [NS][MaxF];
   int unsigned    nframes [NS];
   int unsigned    sent [NS];
   int unsigned    stall_left [NS];
   int unsigned    total_frames, beats, dones;
   int unsigned    stall_pct, cready_pct, oready_pct;
   int             n_checks = 0;
   int             n_fail = 0;
   bit             hold_en, released;
   int unsigned    hold_left;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Source, sink and consumer-side stimulus derived from how far each source has progressed.
   task automatic drive_inputs();
      int unsigned f, p;
      bit active;
      for (int s = 0; s < NS; s++) begin
         f      = sent[s] / FP;
         p      = sent[s] % FP;
         active = f < nframes[s];
         if (stall_left[s] > 0) begin
            stall_left[s]--;
         end else if (active && p != 0 && $urandom_range(99) < stall_pct) begin
            stall_left[s] = 3;
         end
         src_valid[s] = active && (stall_left[s] == 0);
         src_data[s*WIN +: WIN] = active ? pdata[s][sent[s]] : WIN'($urandom);
         if (active && p == 0) src_weights[s*BW +: BW] = wbank[s][f];
         else                  src_weights[s*BW +: BW] = BW'($urandom);
      end
      conv_ready = ($urandom_range(99) < cready_pct);
      if (hold_en && sent[0] == FP && !released) begin
         out_valid = 1'b1;
         if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
         end else begin
            out_ready = 1'b1;
            released  = 1'b1;
         end
      end else begin
         out_valid = 1'($urandom_range(1));
         out_ready = ($urandom_range(99) < oready_pct);
      end
   endtask

   // Reference: one frame per grant, rotating from the source after the previous owner.
   task automatic setup(input int unsigned n0, input int unsigned n1);
      int unsigned left [NS];
      int unsigned fidx [NS];
      int unsigned ptr, s;
      bit found;
      nframes[0] = n0;
      nframes[1] = n1;
      exp_q.delete();
      beats = 0;
      dones = 0;
      total_frames = n0 + n1;
      for (int i = 0; i < NS; i++) begin
         sent[i] = 0;
         stall_left[i] = 0;
         left[i] = nframes[i];
         fidx[i] = 0;
         for (int k = 0; k < MaxF*FP; k++) pdata[i][k] = WIN'($urandom);
         for (int k = 0; k < MaxF; k++) wbank[i][k] = BW'($urandom);
      end
      ptr = 0;
      while (left[0] + left[1] > 0) begin
         found = 1'b0;
         s = 0;
         for (int j = 0; j < NS; j++) begin
            if (!found && left[(ptr + j) % NS] > 0) begin
               found = 1'b1;
               s = (ptr + j) % NS;
            end
         end
         for (int p = 0; p < FP; p++)
            exp_q.push_back('{src: s, data: pdata[s][fidx[s]*FP + p], w: wbank[s][fidx[s]]});
         fidx[s]++;
         left[s]--;
         ptr = (s + 1) % NS;
      end
      drive_inputs();
   endtask

   task automatic step();
      logic [NS-1:0] fired;
      fired = rst ? '0 : (src_valid & src_ready);
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) if (fired[s]) sent[s]++;
      drive_inputs();
      @(negedge clk);
   endtask

   task automatic reset_dut(input int unsigned n0, input int unsigned n1, input int unsigned sp,
                            input int unsigned cp, input int unsigned op);
      rst = 1'b1;
      step();
      stall_pct  = sp;
      cready_pct = cp;
      oready_pct = op;
      hold_en    = 1'b0;
      released   = 1'b0;
      hold_left  = 5;
      setup(n0, n1);
      check("rst_grant", grant, 0);
      check("rst_weights", conv_weights, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_src_ready", src_ready, 0);
      check("rst_conv_valid", conv_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
   endtask

   task automatic run_to_end(input string name);
      int cyc = 0;
      while (dones < total_frames && cyc < 3000) begin
         step();
         cyc++;
      end
      check({name, "_frames_retired"}, dones, total_frames);
      check({name, "_beats_left"}, exp_q.size(), 0);
      step();
      check({name, "_busy_after"}, busy, 0);
   endtask

   // Monitor: compares every forwarded beat and every retirement against the model.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (conv_valid && conv_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got beat from grant %0d, expected none at %0t",
                           grant, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_grant", grant, e.src);
                  check("beat_data", conv_data, e.data);
                  check("beat_weights", conv_weights, e.w);
                  check("beat_src_ready", src_ready, 1 << e.src);
                  beats++;
               end
            end
            check("src_ready_onehot", ($countones(src_ready) <= 1), 1);
            if (frame_done) begin
               check("done_after_full_frame", beats, (dones + 1) * FP);
               check("done_consumer_ok", (!out_valid || out_ready), 1);
               check("done_while_busy", busy, 1);
               dones++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      int cyc;
      rst = 1'b1;
      src_valid = '0;
      src_data = '0;
      src_weights = '0;
      conv_ready = 1'b0;
      out_valid = 1'b0;
      out_ready = 1'b1;
      hold_en = 1'b0;
      released = 1'b0;
      hold_left = 0;
      @(negedge clk);

      // Only source 1 requests.
      reset_dut(0, 1, 0, 100, 100);
      run_to_end("only_src1");

      // Both requesting with random stalls and backpressure; then uneven frame counts.
      reset_dut(3, 3, 15, 75, 70);
      run_to_end("both_random");
      reset_dut(2, 4, 15, 75, 70);
      run_to_end("uneven");

      // Consumer holds the last result: arbiter must sit in drain with grant and weights held.
      reset_dut(1, 1, 0, 100, 100);
      hold_en = 1'b1;
      cyc = 0;
      while (sent[0] < FP && cyc < 200) begin
         step();
         cyc++;
      end
      check("drain_reached", sent[0], FP);
      for (int i = 0; i < 5; i++) begin
         check("drain_busy", busy, 1);
         check("drain_grant", grant, 0);
         check("drain_weights", conv_weights, wbank[0][0]);
         check("drain_no_done", frame_done, 0);
         check("drain_no_new_grant", {conv_valid, src_ready}, 0);
         step();
      end
      check("drain_done_on_ready", frame_done, 1);
      run_to_end("drain_hold");

      // Reset in the middle of a source-1 frame.
      reset_dut(1, 1, 10, 80, 80);
      cyc = 0;
      while (sent[1] < 7 && cyc < 500) begin
         step();
         cyc++;
      end
      check("midframe_progress", sent[1], 7);
      reset_dut(1, 1, 10, 80, 80);
      run_to_end("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
